// File: rtl/char_lcd_ctrl.sv
// char_lcd_ctrl: drives an HD44780-compatible 2x16 character LCD in 4-bit,
// write-only mode. Performs the power-on init, configures the panel, then
// writes line 1 and line 2 from a 32-character string image and idles.
// A refresh pulse in the idle state rewrites both lines without re-init.
//
// Ports:
//   i_clk      system clock
//   i_rst      synchronous active-high reset, restarts from power-up
//   i_strdata  32 ASCII chars, char k = i_strdata[255-8k -: 8]
//   i_refresh  single-cycle request to rewrite both lines (idle only)
//   o_busy     high whenever the controller is not idle
//   o_lcd_e    LCD enable strobe
//   o_lcd_rs   register select (0 command, 1 data)
//   o_lcd_rw   always 0
//   o_lcd_dat  data nibble DB7..DB4
module char_lcd_ctrl #(
    parameter int T_PWRUP = 750000,
    parameter int T_INIT1 = 205000,
    parameter int T_INIT2 = 5000,
    parameter int T_CMD   = 2000,
    parameter int T_CLEAR = 82000,
    parameter int T_EH    = 12,
    parameter int T_SU    = 2,
    parameter int T_NIB   = 50
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [255:0] i_strdata,
    input  logic         i_refresh,
    output logic         o_busy,
    output logic         o_lcd_e,
    output logic         o_lcd_rs,
    output logic         o_lcd_rw,
    output logic [3:0]   o_lcd_dat
);
    localparam int CW = 24;

    typedef enum logic [2:0] {
        S_PWRUP, S_INIT, S_CFG, S_ADDR1, S_LINE1, S_ADDR2, S_LINE2, S_DONE
    } state_t;

    // Per-nibble phases: setup, enable high, inter-nibble gap, post-write wait
    typedef enum logic [1:0] {PH_SU, PH_EH, PH_GAP, PH_POST} phase_t;

    state_t          r_state, w_state_nx;
    phase_t          r_ph, w_ph_nx;
    logic [3:0]      r_step, w_step_nx;
    logic            r_hi, w_hi_nx;
    logic [CW-1:0]   r_cnt, w_cnt_nx;
    logic [7:0]      r_byte, w_byte_nx;
    logic            r_rs, w_rs_nx;
    logic [255:0]    r_buf, w_buf_nx;
    logic            w_start;
    logic [CW-1:0]   w_post;

    // Byte to send for a given operation; init steps only use the high nibble
    function automatic logic [7:0] op_byte(input state_t s, input logic [3:0] step,
                                           input logic [255:0] img);
        logic [7:0] v;
        v = 8'h00;
        case (s)
            S_INIT:  v = (step == 4'd3) ? 8'h20 : 8'h30;
            S_CFG: begin
                case (step[1:0])
                    2'd0:    v = 8'h28;
                    2'd1:    v = 8'h06;
                    2'd2:    v = 8'h0C;
                    default: v = 8'h01;
                endcase
            end
            S_ADDR1: v = 8'h80;
            S_ADDR2: v = 8'hC0;
            S_LINE1: v = img[8'd255 - {1'b0, step, 3'b000} -: 8];
            S_LINE2: v = img[8'd255 - {1'b1, step, 3'b000} -: 8];
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [CW-1:0] op_post(input state_t s, input logic [3:0] step);
        logic [CW-1:0] v;
        v = CW'(T_CMD);
        if (s == S_INIT && step == 4'd0)      v = CW'(T_INIT1);
        else if (s == S_INIT && step == 4'd1) v = CW'(T_INIT2);
        else if (s == S_CFG && step == 4'd3)  v = CW'(T_CLEAR);
        return v;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_PWRUP;
            r_ph    <= PH_SU;
            r_step  <= '0;
            r_hi    <= 1'b1;
            r_cnt   <= '0;
            r_byte  <= '0;
            r_rs    <= 1'b0;
            r_buf   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ph    <= w_ph_nx;
            r_step  <= w_step_nx;
            r_hi    <= w_hi_nx;
            r_cnt   <= w_cnt_nx;
            r_byte  <= w_byte_nx;
            r_rs    <= w_rs_nx;
            r_buf   <= w_buf_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_ph_nx    = r_ph;
        w_step_nx  = r_step;
        w_hi_nx    = r_hi;
        w_cnt_nx   = r_cnt + CW'(1);
        w_byte_nx  = r_byte;
        w_rs_nx    = r_rs;
        w_buf_nx   = r_buf;
        w_start    = 1'b0;
        w_post     = op_post(r_state, r_step);

        case (r_state)
            S_PWRUP: begin
                if (r_cnt == CW'(T_PWRUP - 1)) begin
                    w_state_nx = S_INIT;
                    w_step_nx  = '0;
                    w_start    = 1'b1;
                end
            end
            S_DONE: begin
                w_cnt_nx = '0;
                if (i_refresh) begin
                    w_state_nx = S_ADDR1;
                    w_step_nx  = '0;
                    w_buf_nx   = i_strdata;
                    w_start    = 1'b1;
                end
            end
            default: begin
                case (r_ph)
                    PH_SU: begin
                        if (r_cnt == CW'(T_SU - 1)) begin
                            w_ph_nx  = PH_EH;
                            w_cnt_nx = '0;
                        end
                    end
                    PH_EH: begin
                        if (r_cnt == CW'(T_EH - 1)) begin
                            w_cnt_nx = '0;
                            // init writes are a lone high nibble: no low half
                            w_ph_nx  = (r_hi && r_state != S_INIT) ? PH_GAP : PH_POST;
                        end
                    end
                    PH_GAP: begin
                        if (r_cnt == CW'(T_NIB - 1)) begin
                            w_ph_nx  = PH_SU;
                            w_hi_nx  = 1'b0;
                            w_cnt_nx = '0;
                        end
                    end
                    default: begin
                        if (r_cnt == w_post - CW'(1)) begin
                            w_start   = 1'b1;
                            w_step_nx = r_step + 4'd1;
                            case (r_state)
                                S_INIT:  if (r_step == 4'd3) begin w_state_nx = S_CFG; w_step_nx = '0; end
                                S_CFG: begin
                                    if (r_step == 4'd3) begin
                                        w_state_nx = S_ADDR1;
                                        w_step_nx  = '0;
                                        // snapshot so later strdata changes cannot tear the panel
                                        w_buf_nx   = i_strdata;
                                    end
                                end
                                S_ADDR1: begin w_state_nx = S_LINE1; w_step_nx = '0; end
                                S_LINE1: if (r_step == 4'd15) begin w_state_nx = S_ADDR2; w_step_nx = '0; end
                                S_ADDR2: begin w_state_nx = S_LINE2; w_step_nx = '0; end
                                S_LINE2: begin
                                    if (r_step == 4'd15) begin
                                        w_state_nx = S_DONE;
                                        w_step_nx  = '0;
                                        w_start    = 1'b0;
                                        w_cnt_nx   = '0;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                endcase
            end
        endcase

        // New operation: present its high nibble and rs, then count setup
        if (w_start) begin
            w_ph_nx   = PH_SU;
            w_hi_nx   = 1'b1;
            w_cnt_nx  = '0;
            w_byte_nx = op_byte(w_state_nx, w_step_nx, w_buf_nx);
            w_rs_nx   = (w_state_nx == S_LINE1) || (w_state_nx == S_LINE2);
        end
    end

    assign o_busy    = (r_state != S_DONE);
    assign o_lcd_e   = (r_ph == PH_EH);
    assign o_lcd_rs  = r_rs;
    assign o_lcd_rw  = 1'b0;
    assign o_lcd_dat = r_hi ? r_byte[7:4] : r_byte[3:0];
endmodule

// File: tb/tb_char_lcd_ctrl.sv
module tb_char_lcd_ctrl;
    localparam int T_PWRUP = 20;
    localparam int T_INIT1 = 10;
    localparam int T_INIT2 = 6;
    localparam int T_CMD   = 4;
    localparam int T_CLEAR = 9;
    localparam int T_EH    = 3;
    localparam int T_SU    = 2;
    localparam int T_NIB   = 3;

    logic         clk, rst, refresh;
    logic [255:0] strdata;
    logic         busy, lcd_e, lcd_rs, lcd_rw;
    logic [3:0]   lcd_dat;

    char_lcd_ctrl #(
        .T_PWRUP(T_PWRUP), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_CMD(T_CMD),
        .T_CLEAR(T_CLEAR), .T_EH(T_EH), .T_SU(T_SU), .T_NIB(T_NIB)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_strdata(strdata), .i_refresh(refresh),
        .o_busy(busy), .o_lcd_e(lcd_e), .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw),
        .o_lcd_dat(lcd_dat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected nibble: value, rs, and e-low cycles before the next nibble's rise
    typedef struct {
        logic [3:0] nib;
        logic       rs;
        int         gap_after;
    } exp_t;

    // Observed strobe: data at fall and at rise, high width, low gap before rise
    typedef struct {
        logic [3:0] nib;
        logic       rs;
        logic [3:0] nib_r;
        logic       rs_r;
        int         width;
        int         gap;
    } rec_t;

    exp_t eq[$];
    rec_t mon_q[$];
    int   n_total, n_pass, n_fail, rw_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: turn every e high pulse into one record, outside reset
    initial begin
        int   cyc, rise_cyc, fall_cyc;
        bit   have_fall;
        logic e_prev, rs_r;
        logic [3:0] dat_r;
        rec_t rec;
        cyc = 0; rise_cyc = 0; fall_cyc = 0; have_fall = 0; e_prev = 0;
        rs_r = 0; dat_r = 0; rw_bad = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (lcd_rw !== 1'b0) rw_bad++;
            if (rst) begin
                e_prev = 0;
                have_fall = 0;
            end else begin
                if (lcd_e === 1'b1 && !e_prev) begin
                    rise_cyc = cyc; dat_r = lcd_dat; rs_r = lcd_rs;
                end else if (lcd_e === 1'b0 && e_prev) begin
                    rec.nib = lcd_dat; rec.rs = lcd_rs; rec.nib_r = dat_r; rec.rs_r = rs_r;
                    rec.width = cyc - rise_cyc;
                    rec.gap = have_fall ? rise_cyc - fall_cyc : -1;
                    mon_q.push_back(rec);
                    fall_cyc = cyc; have_fall = 1;
                end
                e_prev = lcd_e;
            end
        end
    end

    // ---- reference model: expected nibble stream from the panel protocol ----
    task automatic push_nib(input logic [3:0] n, input logic rs, input int wait_cyc);
        exp_t e;
        e.nib = n; e.rs = rs; e.gap_after = wait_cyc + T_SU;
        eq.push_back(e);
    endtask

    task automatic push_byte(input logic [7:0] b, input logic rs, input int post);
        push_nib(b[7:4], rs, T_NIB);
        push_nib(b[3:0], rs, post);
    endtask

    task automatic push_init_cfg();
        push_nib(4'h3, 1'b0, T_INIT1);
        push_nib(4'h3, 1'b0, T_INIT2);
        push_nib(4'h3, 1'b0, T_CMD);
        push_nib(4'h2, 1'b0, T_CMD);
        push_byte(8'h28, 1'b0, T_CMD);
        push_byte(8'h06, 1'b0, T_CMD);
        push_byte(8'h0C, 1'b0, T_CMD);
        push_byte(8'h01, 1'b0, T_CLEAR);
    endtask

    task automatic push_lines(input logic [255:0] s);
        logic [7:0] ch;
        push_byte(8'h80, 1'b0, T_CMD);
        for (int k = 0; k < 32; k++) begin
            if (k == 16) push_byte(8'hC0, 1'b0, T_CMD);
            ch = s[255-8*k -: 8];
            push_byte(ch, 1'b1, T_CMD);
        end
    endtask

    function automatic logic [255:0] rand_str();
        logic [255:0] s;
        s = '0;
        for (int k = 0; k < 32; k++) s[255-8*k -: 8] = 8'($urandom_range(32, 126));
        return s;
    endfunction

    // hook_kind 1: overwrite strdata with 'Z's, 2: pulse refresh (both before item hook_at)
    task automatic expect_seq(input string tag, input int n_lim, input int hook_at, input int hook_kind);
        int   n, t;
        rec_t r;
        n = (n_lim < 0) ? eq.size() : n_lim;
        for (int i = 0; i < n; i++) begin
            if (i == hook_at && hook_kind == 1) strdata = {32{8'h5A}};
            if (i == hook_at && hook_kind == 2) begin
                refresh = 1'b1;
                @(negedge clk);
                refresh = 1'b0;
            end
            t = 0;
            while (mon_q.size() == 0 && t < 500) begin
                @(negedge clk);
                t++;
            end
            if (mon_q.size() == 0) begin
                check({tag, "_timeout"}, mon_q.size(), 1);
                return;
            end
            r = mon_q.pop_front();
            check($sformatf("%s_nib%0d", tag, i), {r.nib_r, r.nib, r.rs_r, r.rs},
                  {eq[i].nib, eq[i].nib, eq[i].rs, eq[i].rs});
            check($sformatf("%s_eh%0d", tag, i), r.width, T_EH);
            if (i > 0) check($sformatf("%s_gap%0d", tag, i), r.gap, eq[i-1].gap_after);
        end
    endtask

    task automatic first_rise(input string tag);
        int n;
        n = 0;
        while (lcd_e !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(tag, n, T_PWRUP + T_SU);
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_busy"}, busy, 0);
        check({tag, "_e_idle"}, lcd_e, 0);
        check({tag, "_rs_hold"}, lcd_rs, 1);
    endtask

    initial begin
        logic [255:0] s1, s2, s3;
        n_total = 0; n_pass = 0; n_fail = 0;
        s1 = "* Hello World! *f   d  e  m  b  ";
        s2 = rand_str();
        s3 = rand_str();
        rst = 1'b1; refresh = 1'b0; strdata = s1;

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_e", lcd_e, 0);
        check("rst_rs", lcd_rs, 0);
        check("rst_rw", lcd_rw, 0);
        check("rst_dat", lcd_dat, 0);
        check("rst_busy", busy, 1);
        rst = 1'b0;
        first_rise("boot_first_rise");

        // init, config, lines; strdata clobbered while line 1 is going out
        eq.delete();
        push_init_cfg();
        push_lines(s1);
        expect_seq("boot", -1, 14 + 2*6, 1);
        wait_done("boot");
        repeat (40) @(negedge clk);
        check("boot_no_extra", mon_q.size(), 0);

        // refresh from idle, plus an ignored refresh while busy
        repeat ($urandom_range(1, 20)) @(negedge clk);
        strdata = s2;
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        check("refresh_busy", busy, 1);
        eq.delete();
        push_lines(s2);
        expect_seq("refresh", -1, $urandom_range(2, 60), 2);
        wait_done("refresh");
        repeat (60) @(negedge clk);
        check("refresh_not_queued", mon_q.size(), 0);
        check("refresh_idle", busy, 0);

        // reset while e is high in line 2, with refresh asserted too
        strdata = s3;
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        eq.delete();
        push_lines(s3);
        expect_seq("pre_rst", 36 + 6, -1, 0);
        begin
            int t;
            t = 0;
            while (lcd_e !== 1'b1 && t < 500) begin
                @(negedge clk);
                t++;
            end
            check("pre_rst_e_high", lcd_e, 1);
        end
        rst = 1'b1;
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        check("midrst_e", lcd_e, 0);
        check("midrst_busy", busy, 1);
        check("midrst_dat", lcd_dat, 0);
        check("midrst_rs", lcd_rs, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mon_q.delete();
        first_rise("reboot_first_rise");
        eq.delete();
        push_init_cfg();
        push_lines(s3);
        expect_seq("reboot", -1, -1, 0);
        wait_done("reboot");
        check("rw_always_low", rw_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
